// File: rtl/gpu_draw_pkg.sv
// Shared types and register map for the 2D draw engine: opcodes, FSM states,
// bus addresses and the command snapshot carried through the FIFO.
package gpu_draw_pkg;

    typedef enum logic [1:0] {
        OP_CLEAR   = 2'd0,
        OP_POINT   = 2'd1,
        OP_FILL    = 2'd2,
        OP_OUTLINE = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DRAW = 2'd2
    } state_e;

    localparam logic [15:0] ADDR_P0     = 16'h0004;
    localparam logic [15:0] ADDR_P1     = 16'h0008;
    localparam logic [15:0] ADDR_COLOR  = 16'h000C;
    localparam logic [15:0] ADDR_CMD    = 16'h0010;
    localparam logic [15:0] ADDR_STATUS = 16'h0014;

    // Fields are sized for the widest supported configuration; narrower
    // builds zero-extend on push and use the low bits on pop.
    typedef struct packed {
        op_e         op;
        logic [15:0] x0;
        logic [15:0] y0;
        logic [15:0] x1;
        logic [15:0] y1;
        logic [23:0] color;
    } cmd_t;

endpackage

// File: rtl/gpu_draw_engine_if.sv
// CPU-bus and pixel-stream signals of the draw engine; the engine is the slave
// side, the host/framebuffer side is the master.
interface gpu_draw_engine_if #(
    parameter int XW = 8,
    parameter int YW = 8,
    parameter int CW = 24
);
    logic          bus_en;
    logic          bus_we;
    logic [15:0]   bus_addr;
    logic [31:0]   bus_wdata;
    logic [31:0]   bus_rdata;
    logic          px_valid;
    logic          px_ready;
    logic [XW-1:0] px_x;
    logic [YW-1:0] px_y;
    logic [CW-1:0] px_color;
    logic          busy;

    modport slave (
        input  bus_en, bus_we, bus_addr, bus_wdata, px_ready,
        output bus_rdata, px_valid, px_x, px_y, px_color, busy
    );

    modport master (
        output bus_en, bus_we, bus_addr, bus_wdata, px_ready,
        input  bus_rdata, px_valid, px_x, px_y, px_color, busy
    );
endinterface

// File: rtl/gpu_cmd_fifo.sv
// Synchronous command FIFO with registered read; pop_data is valid the cycle
// after pop. Simultaneous push and pop are both honoured, even when full.
module gpu_cmd_fifo
    import gpu_draw_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] pop_data_reg;
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
        if (do_pop) begin
            pop_data_reg <= mem[rd_ptr_reg];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign pop_data = pop_data_reg;
    assign count    = count_reg;

endmodule

// File: rtl/gpu_draw_engine.sv
// Memory-mapped 2D draw engine: queues CLEAR/POINT/FILL/OUTLINE commands and
// streams clipped pixels in raster order over a valid/ready interface.
module gpu_draw_engine
    import gpu_draw_pkg::*;
#(
    parameter int XW         = 8,
    parameter int YW         = 8,
    parameter int CW         = 24,
    parameter int SCREEN_W   = 200,
    parameter int SCREEN_H   = 150,
    parameter int FIFO_DEPTH = 4
) (
    input logic              clk,
    input logic              reset_n,
    gpu_draw_engine_if.slave io
);
    localparam int            AW    = $clog2(FIFO_DEPTH);
    localparam logic [XW-1:0] X_MAX = XW'(SCREEN_W - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(SCREEN_H - 1);

    logic [XW-1:0] p0_x_reg, p1_x_reg;
    logic [YW-1:0] p0_y_reg, p1_y_reg;
    logic [CW-1:0] color_reg;
    logic          overflow_reg;

    state_e        state_reg;
    op_e           op_reg;
    logic [XW-1:0] x0_reg, x1_reg, cur_x_reg;
    logic [YW-1:0] y0_reg, y1_reg, cur_y_reg;
    logic [CW-1:0] px_color_reg;

    cmd_t          push_cmd;
    cmd_t          pop_cmd;
    logic [AW:0]   fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          bus_write;
    logic          cmd_write;
    logic          fifo_pop;
    logic          busy;
    logic [31:0]   rdata;

    assign bus_write = io.bus_en && io.bus_we;
    assign cmd_write = bus_write && (io.bus_addr == ADDR_CMD);
    assign fifo_pop  = (state_reg == S_IDLE) && !fifo_empty;
    assign busy      = !fifo_empty || (state_reg != S_IDLE);

    always_comb begin
        push_cmd       = '0;
        push_cmd.op    = op_e'(io.bus_wdata[1:0]);
        push_cmd.x0    = 16'(p0_x_reg);
        push_cmd.y0    = 16'(p0_y_reg);
        push_cmd.x1    = 16'(p1_x_reg);
        push_cmd.y1    = 16'(p1_y_reg);
        push_cmd.color = 24'(color_reg);
    end

    gpu_cmd_fifo #(
        .WIDTH ($bits(cmd_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (cmd_write),
        .push_data (push_cmd),
        .pop       (fifo_pop),
        .pop_data  (pop_cmd),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            p0_x_reg     <= '0;
            p0_y_reg     <= '0;
            p1_x_reg     <= '0;
            p1_y_reg     <= '0;
            color_reg    <= '0;
            overflow_reg <= 1'b0;
        end else if (bus_write) begin
            case (io.bus_addr)
                ADDR_P0: begin
                    p0_x_reg <= io.bus_wdata[XW-1:0];
                    p0_y_reg <= io.bus_wdata[16 +: YW];
                end
                ADDR_P1: begin
                    p1_x_reg <= io.bus_wdata[XW-1:0];
                    p1_y_reg <= io.bus_wdata[16 +: YW];
                end
                ADDR_COLOR:  color_reg <= io.bus_wdata[CW-1:0];
                ADDR_CMD:    if (fifo_full && !fifo_pop) overflow_reg <= 1'b1;
                ADDR_STATUS: if (io.bus_wdata[2]) overflow_reg <= 1'b0;
                default: ;
            endcase
        end
    end

    // Normalise, substitute CLEAR/POINT bounds, then clip the far corner.
    logic [XW-1:0] ax, bx, ld_x0, ld_x1;
    logic [YW-1:0] ay, by, ld_y0, ld_y1;
    logic          ld_off;

    always_comb begin
        ax    = pop_cmd.x0[XW-1:0];
        bx    = pop_cmd.x1[XW-1:0];
        ay    = pop_cmd.y0[YW-1:0];
        by    = pop_cmd.y1[YW-1:0];
        ld_x0 = (ax <= bx) ? ax : bx;
        ld_x1 = (ax <= bx) ? bx : ax;
        ld_y0 = (ay <= by) ? ay : by;
        ld_y1 = (ay <= by) ? by : ay;
        case (pop_cmd.op)
            OP_CLEAR: begin
                ld_x0 = '0;
                ld_y0 = '0;
                ld_x1 = X_MAX;
                ld_y1 = Y_MAX;
            end
            OP_POINT: begin
                ld_x0 = ax;
                ld_x1 = ax;
                ld_y0 = ay;
                ld_y1 = ay;
            end
            default: ;
        endcase
        if (ld_x1 > X_MAX) ld_x1 = X_MAX;
        if (ld_y1 > Y_MAX) ld_y1 = Y_MAX;
        ld_off = (ld_x0 > X_MAX) || (ld_y0 > Y_MAX);
    end

    logic row_end, last_px, skip_interior;
    assign row_end       = (cur_x_reg == x1_reg);
    assign last_px       = row_end && (cur_y_reg == y1_reg);
    assign skip_interior = (op_reg == OP_OUTLINE) && (cur_x_reg == x0_reg) &&
                           (cur_y_reg != y0_reg) && (cur_y_reg != y1_reg);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg    <= S_IDLE;
            op_reg       <= OP_CLEAR;
            x0_reg       <= '0;
            x1_reg       <= '0;
            y0_reg       <= '0;
            y1_reg       <= '0;
            cur_x_reg    <= '0;
            cur_y_reg    <= '0;
            px_color_reg <= '0;
        end else begin
            case (state_reg)
                S_IDLE: if (!fifo_empty) state_reg <= S_LOAD;
                S_LOAD: begin
                    if (ld_off) begin
                        state_reg <= S_IDLE;
                    end else begin
                        state_reg    <= S_DRAW;
                        op_reg       <= pop_cmd.op;
                        x0_reg       <= ld_x0;
                        x1_reg       <= ld_x1;
                        y0_reg       <= ld_y0;
                        y1_reg       <= ld_y1;
                        cur_x_reg    <= ld_x0;
                        cur_y_reg    <= ld_y0;
                        px_color_reg <= pop_cmd.color[CW-1:0];
                    end
                end
                S_DRAW: begin
                    if (io.px_ready) begin
                        if (last_px) begin
                            state_reg <= S_IDLE;
                        end else if (row_end) begin
                            cur_x_reg <= x0_reg;
                            cur_y_reg <= cur_y_reg + 1'b1;
                        end else if (skip_interior) begin
                            cur_x_reg <= x1_reg;
                        end else begin
                            cur_x_reg <= cur_x_reg + 1'b1;
                        end
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        rdata = '0;
        case (io.bus_addr)
            ADDR_P0: begin
                rdata[XW-1:0]  = p0_x_reg;
                rdata[16 +: YW] = p0_y_reg;
            end
            ADDR_P1: begin
                rdata[XW-1:0]  = p1_x_reg;
                rdata[16 +: YW] = p1_y_reg;
            end
            ADDR_COLOR: rdata[CW-1:0] = color_reg;
            ADDR_STATUS: begin
                rdata[0]    = busy;
                rdata[1]    = fifo_full;
                rdata[2]    = overflow_reg;
                rdata[15:8] = 8'(fifo_count);
            end
            default: ;
        endcase
    end

    // Upper bus bits and widened snapshot fields are intentionally ignored.
    logic unused_bits;
    assign unused_bits = ^{io.bus_wdata, pop_cmd};

    assign io.bus_rdata = rdata;
    assign io.px_valid  = (state_reg == S_DRAW);
    assign io.px_x      = cur_x_reg;
    assign io.px_y      = cur_y_reg;
    assign io.px_color  = px_color_reg;
    assign io.busy      = busy;

endmodule
